// File: rtl/agc_timepulse_sched.sv
// AGC time-pulse sequencer: one-hot T01..T(NT) with sub-phases, run/drain/step control of MCTs.
// Optional `ifdef TPG_STALL_EN adds a stall input that freezes the sequence while busy.
module agc_timepulse_sched #(
  parameter int DIV    = 2,
  parameter int NPHASE = 4,
  parameter int NT     = 12,
  parameter int CW     = 16
) (
  input  logic                      SIM_CLK,
  input  logic                      SIM_RST,
  input  logic                      run,
  input  logic                      step_req,
`ifdef TPG_STALL_EN
  input  logic                      stall,
`endif
  output logic                      step_ack,
  output logic [NT-1:0]             tpulse,
  output logic [$clog2(NPHASE)-1:0] phase,
  output logic                      phase_tick,
  output logic                      mct_end,
  output logic [CW-1:0]             mct_count,
  output logic                      busy
);

  localparam int PW = $clog2(NPHASE);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    STEP  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   div, div_n;
  logic [PW-1:0]   phase_n;
  logic [NT-1:0]   tpulse_n;
  logic [CW-1:0]   count_n;
  logic            ack_n, tick_n, end_n, busy_n;
  logic            start, advance;
  logic            stall_i, hold;
  logic            div_last, phase_last, at_end;

`ifdef TPG_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  // Boundary detection uses the internal position, not the registered flags,
  // so a boundary held by a stall still fires once the stall lifts.
  assign div_last   = (div == DW'(DIV - 1));
  assign phase_last = (phase == PW'(NPHASE - 1));
  assign at_end     = (state != IDLE) && div_last && phase_last && tpulse[NT-1];
  assign hold       = stall_i && (state != IDLE);

  always_comb begin
    state_n  = state;
    div_n    = div;
    phase_n  = phase;
    tpulse_n = tpulse;
    count_n  = mct_count;
    ack_n    = 1'b0;
    start    = 1'b0;
    advance  = 1'b0;

    case (state)
      IDLE: begin
        if (run) begin
          state_n = RUN;
          start   = 1'b1;
        end else if (step_req) begin
          state_n = STEP;
          start   = 1'b1;
        end
      end
      RUN, DRAIN, STEP: begin
        if (!hold) begin
          if (at_end) begin
            count_n = mct_count + 1'b1;
            if (state == STEP) begin
              state_n = IDLE;
              ack_n   = 1'b1;
            end else if (run) begin
              state_n = RUN;
              start   = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            advance = 1'b1;
            if (state != STEP) state_n = run ? RUN : DRAIN;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (start) begin
      div_n    = '0;
      phase_n  = '0;
      tpulse_n = NT'(1);
    end else if (advance) begin
      div_n = div_last ? '0 : div + 1'b1;
      if (div_last) begin
        phase_n = phase_last ? '0 : phase + 1'b1;
        if (phase_last) tpulse_n = {tpulse[NT-2:0], tpulse[NT-1]};
      end
    end else if (state_n == IDLE) begin
      div_n    = '0;
      phase_n  = '0;
      tpulse_n = '0;
    end

    busy_n = (state_n != IDLE);
    tick_n = busy_n && !hold && (div_n == DW'(DIV - 1));
    end_n  = tick_n && (phase_n == PW'(NPHASE - 1)) && tpulse_n[NT-1];
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state      <= IDLE;
      div        <= '0;
      phase      <= '0;
      tpulse     <= '0;
      mct_count  <= '0;
      step_ack   <= 1'b0;
      phase_tick <= 1'b0;
      mct_end    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      div        <= div_n;
      phase      <= phase_n;
      tpulse     <= tpulse_n;
      mct_count  <= count_n;
      step_ack   <= ack_n;
      phase_tick <= tick_n;
      mct_end    <= end_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_agc_timepulse_sched.sv
// Self-checking bench for agc_timepulse_sched: directed scenarios plus randomized run/step
// traffic compared against a position-based reference model.
module tb_agc_timepulse_sched;

  localparam int DIV    = 2;
  localparam int NPHASE = 4;
  localparam int NT     = 12;
  localparam int CW     = 16;
  localparam int PW     = $clog2(NPHASE);
  localparam int L      = NT * NPHASE * DIV;

  logic          SIM_CLK = 1'b0;
  logic          SIM_RST = 1'b0;
  logic          run = 1'b0;
  logic          step_req = 1'b0;
  logic          stall_v = 1'b0;
  logic          step_ack;
  logic [NT-1:0] tpulse;
  logic [PW-1:0] phase;
  logic          phase_tick;
  logic          mct_end;
  logic [CW-1:0] mct_count;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // reference model: position within the MCT and a few mode bits
  int          m_pos   = 0;
  bit          m_busy  = 0;
  bit          m_step  = 0;
  bit          m_ack   = 0;
  int unsigned m_count = 0;

  agc_timepulse_sched #(.DIV(DIV), .NPHASE(NPHASE), .NT(NT), .CW(CW)) dut (
    .SIM_CLK    (SIM_CLK),
    .SIM_RST    (SIM_RST),
    .run        (run),
    .step_req   (step_req),
`ifdef TPG_STALL_EN
    .stall      (stall_v),
`endif
    .step_ack   (step_ack),
    .tpulse     (tpulse),
    .phase      (phase),
    .phase_tick (phase_tick),
    .mct_end    (mct_end),
    .mct_count  (mct_count),
    .busy       (busy)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  task automatic tick();
    @(posedge SIM_CLK);
    m_ack = 0;
    if (!(stall_v && m_busy)) begin
      if (!m_busy) begin
        if (run || step_req) begin
          m_busy = 1;
          m_step = !run;
          m_pos  = 0;
        end
      end else if (m_pos == L - 1) begin
        m_count = (m_count + 1) % (1 << CW);
        m_ack   = m_step;
        if (m_step || !run) m_busy = 0;
        else m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    run = 0; step_req = 0; stall_v = 0;
    @(negedge SIM_CLK);
    SIM_RST = 1;
    #2;
    SIM_RST = 0;
    m_pos = 0; m_busy = 0; m_step = 0; m_ack = 0; m_count = 0;
    @(negedge SIM_CLK);
  endtask

  task automatic test_reset();
    run = 1;
    tick(); tick(); tick();
    @(negedge SIM_CLK);
    SIM_RST = 1;
    #1;
    total++; if (tpulse !== '0) begin bad++; $display("FAIL reset_tpulse got=%h want=0", tpulse); end
    total++; if (phase !== '0) begin bad++; $display("FAIL reset_phase got=%0d want=0", phase); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (phase_tick !== 1'b0 || mct_end !== 1'b0 || step_ack !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b%b want=000", phase_tick, mct_end, step_ack);
    end
    total++; if (mct_count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", mct_count); end
    #2;
    SIM_RST = 0;
    run = 0;
    m_pos = 0; m_busy = 0; m_step = 0; m_ack = 0; m_count = 0;
    @(negedge SIM_CLK);
  endtask

  task automatic test_run_first_mct();
    int n;
    do_reset();
    run = 1;
    for (int c = 1; c <= 97; c++) begin
      tick();
      if (c == 1) begin
        total++; if (tpulse !== 12'h001 || busy !== 1'b1 || phase !== '0) begin
          bad++; $display("FAIL run_start got tp=%h busy=%b ph=%0d want 001/1/0", tpulse, busy, phase);
        end
      end
      if (c == 9) begin
        total++; if (tpulse !== 12'h002) begin bad++; $display("FAIL run_t02 got=%h want=002", tpulse); end
      end
      if (c <= 96) begin
        total++; if (phase_tick !== ((c % 2) == 0)) begin
          bad++; $display("FAIL run_tick c=%0d got=%b want=%b", c, phase_tick, (c % 2) == 0);
        end
        total++; if (mct_end !== (c == 96)) begin
          bad++; $display("FAIL run_end c=%0d got=%b want=%b", c, mct_end, c == 96);
        end
      end
    end
    total++; if (mct_count !== 16'd1 || tpulse !== 12'h001) begin
      bad++; $display("FAIL run_boundary got cnt=%0d tp=%h want 1/001", mct_count, tpulse);
    end
    run = 0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin tick(); n++; end
    total++; if (busy !== 1'b0 || mct_count !== 16'd2) begin
      bad++; $display("FAIL run_stop got busy=%b cnt=%0d want 0/2", busy, mct_count);
    end
  endtask

  task automatic test_drain();
    do_reset();
    run = 1;
    for (int c = 1; c <= 3; c++) tick();
    run = 0;
    for (int c = 4; c <= 97; c++) begin
      tick();
      if (c <= 96) begin
        total++; if (mct_end !== (c == 96) || busy !== 1'b1) begin
          bad++; $display("FAIL drain c=%0d got end=%b busy=%b want %b/1", c, mct_end, busy, c == 96);
        end
      end
    end
    total++; if (tpulse !== '0 || busy !== 1'b0 || mct_count !== 16'd1) begin
      bad++; $display("FAIL drain_idle got tp=%h busy=%b cnt=%0d want 0/0/1", tpulse, busy, mct_count);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_stay got busy=%b want=0", busy); end
    end
  endtask

  task automatic test_step();
    int n;
    do_reset();
    step_req = 1;
    for (int c = 1; c <= 97; c++) begin
      tick();
      if (c <= 96) begin
        total++; if (step_ack !== 1'b0 || busy !== 1'b1 || mct_end !== (c == 96)) begin
          bad++; $display("FAIL step c=%0d got ack=%b busy=%b end=%b", c, step_ack, busy, mct_end);
        end
      end
    end
    total++; if (step_ack !== 1'b1 || busy !== 1'b0 || mct_count !== 16'd1) begin
      bad++; $display("FAIL step_ack got ack=%b busy=%b cnt=%0d want 1/0/1", step_ack, busy, mct_count);
    end
    step_req = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (step_ack !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL step_once got ack=%b busy=%b want 0/0", step_ack, busy);
      end
    end
    step_req = 1;
    for (int c = 1; c <= 98; c++) tick();
    total++; if (busy !== 1'b1 || tpulse !== 12'h001 || mct_count !== 16'd2) begin
      bad++; $display("FAIL step_level got busy=%b tp=%h cnt=%0d want 1/001/2", busy, tpulse, mct_count);
    end
    step_req = 0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin tick(); n++; end
    total++; if (busy !== 1'b0 || mct_count !== 16'd3) begin
      bad++; $display("FAIL step_level_done got busy=%b cnt=%0d want 0/3", busy, mct_count);
    end
  endtask

  task automatic test_run_step_together();
    int n;
    int acks;
    do_reset();
    run = 1; step_req = 1;
    tick();
    step_req = 0;
    acks = 0;
    for (int c = 2; c <= 5; c++) tick();
    run = 0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin tick(); n++; if (step_ack) acks++; end
    for (int i = 0; i < 4; i++) begin tick(); if (step_ack) acks++; end
    total++; if (acks !== 0) begin bad++; $display("FAIL together_ack got=%0d want=0", acks); end
    total++; if (mct_count !== 16'd1 || busy !== 1'b0) begin
      bad++; $display("FAIL together_count got cnt=%0d busy=%b want 1/0", mct_count, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1;
    for (int c = 1; c <= 149; c++) tick();
    total++; if (tpulse !== 12'h040 || phase !== 2'd2 || mct_count !== 16'd1) begin
      bad++; $display("FAIL mid_pos got tp=%h ph=%0d cnt=%0d want 040/2/1", tpulse, phase, mct_count);
    end
    #2;
    SIM_RST = 1;
    #1;
    total++; if (tpulse !== '0 || busy !== 1'b0 || mct_end !== 1'b0 || mct_count !== '0 || phase !== '0) begin
      bad++; $display("FAIL mid_reset got tp=%h busy=%b end=%b cnt=%0d ph=%0d want all 0",
                      tpulse, busy, mct_end, mct_count, phase);
    end
    run = 0;
    @(negedge SIM_CLK);
    SIM_RST = 0;
    m_pos = 0; m_busy = 0; m_step = 0; m_ack = 0; m_count = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (busy !== 1'b0 || mct_end !== 1'b0 || tpulse !== '0) begin
        bad++; $display("FAIL mid_idle got busy=%b end=%b tp=%h want 0/0/0", busy, mct_end, tpulse);
      end
    end
  endtask

`ifdef TPG_STALL_EN
  task automatic test_stall();
    do_reset();
    run = 1;
    for (int c = 1; c <= 18; c++) tick();
    stall_v = 1;
    for (int c = 19; c <= 28; c++) begin
      tick();
      total++; if (tpulse !== 12'h004 || phase_tick !== 1'b0 || mct_end !== 1'b0) begin
        bad++; $display("FAIL stall_hold c=%0d got tp=%h tick=%b end=%b want 004/0/0", c, tpulse, phase_tick, mct_end);
      end
    end
    stall_v = 0;
    for (int c = 29; c <= 107; c++) begin
      tick();
      if (c <= 106) begin
        total++; if (mct_end !== (c == 106)) begin
          bad++; $display("FAIL stall_end c=%0d got=%b want=%b", c, mct_end, c == 106);
        end
      end
    end
    total++; if (mct_count !== 16'd1) begin bad++; $display("FAIL stall_count got=%0d want=1", mct_count); end
    run = 0;
    for (int i = 0; i < 100; i++) tick();
  endtask
`endif

  task automatic test_random();
    logic [NT-1:0] one;
    logic [NT-1:0] e_tp;
    do_reset();
    one = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) step_req = ~step_req;
      tick();
      e_tp = m_busy ? (one << (m_pos / (NPHASE * DIV))) : '0;
      total++; if (tpulse !== e_tp) begin bad++; $display("FAIL rnd_tpulse i=%0d got=%h want=%h", i, tpulse, e_tp); end
      total++; if (phase !== PW'(m_busy ? (m_pos / DIV) % NPHASE : 0)) begin
        bad++; $display("FAIL rnd_phase i=%0d got=%0d want=%0d", i, phase, m_busy ? (m_pos / DIV) % NPHASE : 0);
      end
      total++; if (phase_tick !== (m_busy && (m_pos % DIV) == DIV - 1)) begin
        bad++; $display("FAIL rnd_tick i=%0d got=%b", i, phase_tick);
      end
      total++; if (mct_end !== (m_busy && m_pos == L - 1)) begin
        bad++; $display("FAIL rnd_end i=%0d got=%b", i, mct_end);
      end
      total++; if (busy !== m_busy || step_ack !== m_ack) begin
        bad++; $display("FAIL rnd_ctl i=%0d got busy=%b ack=%b want %b/%b", i, busy, step_ack, m_busy, m_ack);
      end
      total++; if (mct_count !== CW'(m_count)) begin
        bad++; $display("FAIL rnd_count i=%0d got=%0d want=%0d", i, mct_count, m_count);
      end
      if (busy) begin
        total++; if (!$onehot(tpulse)) begin bad++; $display("FAIL rnd_onehot i=%0d got=%h", i, tpulse); end
      end
    end
  endtask

  initial begin
    SIM_RST = 1;
    #12;
    SIM_RST = 0;
    @(negedge SIM_CLK);
    test_reset();
    test_run_first_mct();
    test_drain();
    test_step();
    test_run_step_together();
    test_reset_mid();
`ifdef TPG_STALL_EN
    test_stall();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
